// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display arbiter.
// Holds the display constants, the arbiter state encoding and small helpers
// for priority selection, requester slice selection and digit/anode mapping.
package ssd_pkg;

    localparam logic [3:0]  CHAR_DASH  = 4'hA;
    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NUM_REQ    = 3;
    localparam logic [15:0] DASH_FRAME = {NUM_DIGITS{CHAR_DASH}};

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    // One-hot of the lowest-index set bit; bit 0 is the highest priority.
    function automatic logic [2:0] pick_highest(input logic [2:0] r);
        logic [2:0] g;
        g = '0;
        if (r[0])      g = 3'b001;
        else if (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
        return g;
    endfunction

    // Characters of the one-hot owner; dashes when nobody owns the display.
    function automatic logic [15:0] owner_slice(input logic [2:0]  g,
                                                input logic [47:0] d);
        logic [15:0] s;
        case (g)
            3'b001:  s = d[15:0];
            3'b010:  s = d[31:16];
            3'b100:  s = d[47:32];
            default: s = DASH_FRAME;
        endcase
        return s;
    endfunction

    // Active-low anode pattern; digit 0 is the leftmost.
    function automatic logic [3:0] anode_for(input logic [1:0] p);
        logic [3:0] a;
        case (p)
            2'd0:    a = 4'b0111;
            2'd1:    a = 4'b1011;
            2'd2:    a = 4'b1101;
            default: a = 4'b1110;
        endcase
        return a;
    endfunction

    // Character for a digit position; digit 0 takes the top nibble.
    function automatic logic [3:0] digit_of(input logic [15:0] f,
                                            input logic [1:0]  p);
        logic [3:0] c;
        case (p)
            2'd0:    c = f[15:12];
            2'd1:    c = f[11:8];
            2'd2:    c = f[7:4];
            default: c = f[3:0];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ssd_refresh_timer.sv
// Digit-scan timing for the seven-segment display.
// A prescaler counts 0..REFRESH_DIV-1; tick is high while it sits on the
// last count. The digit pointer advances on every tick and wraps 3->0; the
// tick that takes it from 3 to 0 is the frame boundary.
//   clk, reset : system clock, asynchronous active-high reset
//   tick       : one-cycle strobe at the end of each digit slot
//   boundary   : tick that closes a full frame (ptr == 3)
//   ptr        : current digit index, reset value 3
module ssd_refresh_timer #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tick,
    output logic       boundary,
    output logic [1:0] ptr
);

    localparam int unsigned       CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]     CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick     = (cnt == CNT_LAST);
    assign boundary = tick && (ptr == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ptr <= 2'd3;
        end else if (tick) begin
            cnt <= '0;
            ptr <= ptr + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Seven-segment display arbiter.
// Shares a 4-digit display between three requesters with strict priority
// (req[0] highest) and a minimum ownership time of HOLD_FRAMES frames.
// Requests are sampled only at frame boundaries; the owner's characters are
// latched once per frame and scanned out one digit per REFRESH_DIV cycles.
// With no owner, four dashes are shown.
//   clk, reset  : system clock, asynchronous active-high reset
//   req         : request lines, req[0] highest priority
//   req_data    : requester n drives [16n+15:16n], top nibble is leftmost
//   AN          : active-low anode enables, 1111 until the first boundary
//   char_code   : character for the enabled digit, to the segment decoder
//   grant       : one-hot owner, 000 when idle
//   frame_start : one-cycle pulse after each frame boundary edge
module ssd_display_arbiter
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [47:0] req_data,
    output logic [3:0]  AN,
    output logic [3:0]  char_code,
    output logic [2:0]  grant,
    output logic        frame_start
);

    localparam int unsigned   HW       = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

    logic        tick;
    logic        boundary;
    logic [1:0]  ptr;
    logic [1:0]  ptr_nxt;

    state_t      state,    state_nxt;
    logic [2:0]  grant_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [15:0] frame_buf, frame_buf_nxt;

    logic [2:0]  others;
    logic        owner_req;

    ssd_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .boundary (boundary),
        .ptr      (ptr)
    );

    assign ptr_nxt   = ptr + 2'd1;
    assign others    = req & ~grant;
    assign owner_req = |(req & grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            hold_cnt  <= '0;
            frame_buf <= DASH_FRAME;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            hold_cnt  <= hold_nxt;
            frame_buf <= frame_buf_nxt;
        end
    end

    // Arbitration only happens on boundary cycles, so outside them every
    // next-state value simply holds.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        hold_nxt      = hold_cnt;
        frame_buf_nxt = frame_buf;
        if (boundary) begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state_nxt = OWNED;
                        grant_nxt = pick_highest(req);
                        hold_nxt  = '0;
                    end
                end
                OWNED: begin
                    if (!owner_req) begin
                        // Owner let go: release regardless of hold time.
                        hold_nxt = '0;
                        if (|others) begin
                            grant_nxt = pick_highest(others);
                        end else begin
                            state_nxt = IDLE;
                            grant_nxt = '0;
                        end
                    end else if (hold_cnt < HOLD_MAX) begin
                        hold_nxt = hold_cnt + HW'(1);
                    end else if (|others) begin
                        grant_nxt = pick_highest(others);
                        hold_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    hold_nxt  = '0;
                end
            endcase
            // Reload every frame so mid-frame data changes surface at the
            // next frame; an empty grant yields the dash pattern.
            frame_buf_nxt = owner_slice(grant_nxt, req_data);
        end
    end

    // Digit 0 of a new frame reads frame_buf_nxt so the freshly granted
    // characters appear on the same edge as the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AN          <= AN_OFF;
            char_code   <= CHAR_DASH;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (tick) begin
                AN        <= anode_for(ptr_nxt);
                char_code <= digit_of(frame_buf_nxt, ptr_nxt);
            end
        end
    end

endmodule
